// File: rtl/ptc_sar_tracker.sv
// Phase-to-code controller: SAR acquisition of the delay-line code from the
// phase-detector decision, optional +/-1 LSB tracking with lock detection.
module ptc_sar_tracker #(
  parameter int WIDTH       = 10,
  parameter int COARSE_BITS = 4,
  parameter int SETTLE      = 4,
  parameter int LOCK_CNT    = 8
) (
  input  logic                      CLK_exit,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      track_en,
  input  logic                      COMP,
  output logic                      Reset_PD,
  output logic [WIDTH-1:0]          Q,
  output logic [2**COARSE_BITS-1:0] T,
  output logic [2**COARSE_BITS-1:0] Tb,
  output logic                      busy,
  output logic                      done,
  output logic                      locked
);

  localparam int NT = 2**COARSE_BITS;
  localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
  localparam int LW = $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {IDLE, CLR, WAIT, EVAL} state_t;

  state_t            state, state_n;
  logic [WIDTH-1:0]  q, q_n;
  logic [PW-1:0]     ptr, ptr_n;
  logic [SW-1:0]     scnt, scnt_n;
  logic [LW-1:0]     rcnt, rcnt_n;
  logic              last_dir, last_dir_n;
  logic              first, first_n;     // next tracking EVAL only seeds last_dir
  logic              trk, trk_n;         // 0 = SAR mode, 1 = tracking mode
  logic              done_r, done_n;
  logic              lock_r, lock_n;

  always_ff @(posedge CLK_exit) begin
    if (!rst_n) begin
      state    <= IDLE;
      q        <= '0;
      ptr      <= '0;
      scnt     <= '0;
      rcnt     <= '0;
      last_dir <= 1'b0;
      first    <= 1'b0;
      trk      <= 1'b0;
      done_r   <= 1'b0;
      lock_r   <= 1'b0;
    end else begin
      state    <= state_n;
      q        <= q_n;
      ptr      <= ptr_n;
      scnt     <= scnt_n;
      rcnt     <= rcnt_n;
      last_dir <= last_dir_n;
      first    <= first_n;
      trk      <= trk_n;
      done_r   <= done_n;
      lock_r   <= lock_n;
    end
  end

  always_comb begin
    state_n    = state;
    q_n        = q;
    ptr_n      = ptr;
    scnt_n     = scnt;
    rcnt_n     = rcnt;
    last_dir_n = last_dir;
    first_n    = first;
    trk_n      = trk;
    done_n     = 1'b0;
    lock_n     = lock_r;
    case (state)
      IDLE: if (start) begin
        q_n            = '0;
        q_n[WIDTH-1]   = 1'b1;
        ptr_n          = PW'(WIDTH - 1);
        trk_n          = 1'b0;
        state_n        = CLR;
      end
      CLR: begin
        scnt_n  = '0;
        state_n = WAIT;
      end
      WAIT: begin
        scnt_n = scnt + SW'(1);
        if (scnt == SW'(SETTLE - 1)) state_n = EVAL;
      end
      EVAL: begin
        if (!trk) begin
          if (!COMP) q_n[ptr] = 1'b0;
          if (ptr != '0) begin
            q_n[ptr - PW'(1)] = 1'b1;
            ptr_n             = ptr - PW'(1);
            state_n           = CLR;
          end else begin
            done_n = 1'b1;
            if (track_en) begin
              trk_n   = 1'b1;
              first_n = 1'b1;
              rcnt_n  = '0;
              state_n = CLR;
            end else begin
              state_n = IDLE;
            end
          end
        end else if (!track_en) begin
          trk_n   = 1'b0;
          lock_n  = 1'b0;
          state_n = IDLE;
        end else begin
          // saturated steps still register as a direction for lock detection
          if (COMP) begin
            if (q != '1) q_n = q + WIDTH'(1);
          end else begin
            if (q != '0) q_n = q - WIDTH'(1);
          end
          last_dir_n = COMP;
          first_n    = 1'b0;
          if (!first) begin
            if (COMP != last_dir) begin
              if (rcnt != LW'(LOCK_CNT)) rcnt_n = rcnt + LW'(1);
              if (rcnt >= LW'(LOCK_CNT - 1)) lock_n = 1'b1;
            end else begin
              rcnt_n = '0;
              lock_n = 1'b0;
            end
          end
          state_n = CLR;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  logic [COARSE_BITS-1:0] coarse;
  assign coarse = q[WIDTH-1 -: COARSE_BITS];

  for (genvar g = 0; g < NT; g++) begin : g_therm
    assign T[g] = (coarse > COARSE_BITS'(g));
  end

  assign Tb       = ~T;
  assign Q        = q;
  assign Reset_PD = (state == CLR);
  assign busy     = (state != IDLE);
  assign done     = done_r;
  assign locked   = lock_r;

endmodule

// File: tb/tb_ptc_sar_tracker.sv
// Directed bench for ptc_sar_tracker: decision-level reference model compared
// every cycle, plus hand-computed literal checkpoints.
module tb_ptc_sar_tracker;
  localparam int W   = 10;
  localparam int CB  = 4;
  localparam int ST  = 4;
  localparam int LC  = 8;
  localparam int P   = ST + 2;
  localparam int MAXQ = (1 << W) - 1;

  logic          clk = 1'b0;
  logic          rst_n, start, track_en, COMP;
  logic          Reset_PD, busy, done, locked;
  logic [W-1:0]  Q;
  logic [15:0]   T, Tb;
  logic [1:0]    pd_mode;   // 0 = threshold model, 1 = stuck 1, 2 = stuck 0
  int            thr;

  int checks = 0;
  int errors = 0;

  ptc_sar_tracker #(.WIDTH(W), .COARSE_BITS(CB), .SETTLE(ST), .LOCK_CNT(LC)) dut (
    .CLK_exit(clk), .rst_n(rst_n), .start(start), .track_en(track_en), .COMP(COMP),
    .Reset_PD(Reset_PD), .Q(Q), .T(T), .Tb(Tb), .busy(busy), .done(done), .locked(locked)
  );

  always #5 clk = ~clk;

  assign COMP = (pd_mode == 2'd1) ? 1'b1 : (pd_mode == 2'd2) ? 1'b0 : (int'(Q) <= thr);

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Reference model: one record per decision, no FSM encoding.
  bit m_valid = 0, m_busy = 0, m_trk = 0, m_done = 0, m_lock = 0;
  int m_q = 0, m_t = 0, m_k = 0;
  bit hist[$];

  function automatic int therm(input int q);
    int t = 0;
    for (int i = 0; i < 16; i++) if ((q >> (W - CB)) > i) t |= (1 << i);
    return t;
  endfunction

  function automatic int trailing_rev(input bit h[$]);
    int n = 0;
    for (int i = h.size() - 1; i >= 1; i--) begin
      if (h[i] != h[i-1]) n++;
      else break;
    end
    return n;
  endfunction

  always @(negedge clk) begin
    if (m_valid) begin
      chk("Q", int'(Q), m_q);
      chk("T", int'(T), therm(m_q));
      chk("Tb", int'(Tb), therm(m_q) ^ 16'hFFFF);
      chk("Reset_PD", int'(Reset_PD), int'(m_busy && m_t == 0));
      chk("busy", int'(busy), int'(m_busy));
      chk("done", int'(done), int'(m_done));
      chk("locked", int'(locked), int'(m_lock));
    end
    // advance to the state after the coming rising edge
    if (!rst_n) begin
      m_busy = 0; m_trk = 0; m_done = 0; m_lock = 0; m_q = 0; m_t = 0; m_k = 0;
      hist.delete();
      m_valid = 1;
    end else if (m_valid) begin
      m_done = 0;
      if (!m_busy) begin
        if (start) begin m_busy = 1; m_t = 0; m_k = 0; m_trk = 0; m_q = 1 << (W - 1); end
      end else if (m_t < P - 1) begin
        m_t++;
      end else begin
        int b;
        m_t = 0;
        if (!m_trk) begin
          b = W - 1 - m_k;
          if (!COMP) m_q -= (1 << b);
          if (b > 0) begin m_q += (1 << (b - 1)); m_k++; end
          else begin
            m_done = 1;
            if (track_en) begin m_trk = 1; hist.delete(); end
            else m_busy = 0;
          end
        end else if (!track_en) begin
          m_busy = 0; m_trk = 0; m_lock = 0;
        end else begin
          if (COMP) m_q = (m_q == MAXQ) ? m_q : m_q + 1;
          else      m_q = (m_q == 0) ? 0 : m_q - 1;
          hist.push_back(COMP);
          if (hist.size() > 4 * LC) void'(hist.pop_front());
          m_lock = (trailing_rev(hist) >= LC);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  // Pulse start, then count cycles (1 = first cycle after start is sampled).
  task automatic run_sar(input int glitch, output int dn, output int pulses, output int lastp);
    int n = 0;
    dn = 0; pulses = 0; lastp = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    if (glitch > 0) fork
      begin repeat (glitch) tick(); start = 1'b1; tick(); start = 1'b0; end
    join_none
    while (dn == 0 && n < 200) begin
      @(negedge clk);
      n++;
      if (Reset_PD) begin pulses++; lastp = n; end
      if (done) dn = n;
    end
  endtask

  int dn, pulses, lastp, k, bad, qh;

  initial begin
    rst_n = 1'b0; start = 1'b0; track_en = 1'b0; pd_mode = 2'd0; thr = 677;
    repeat (3) tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_Q", int'(Q), 0);
    chk("reset_Tb", int'(Tb), 16'hFFFF);
    chk("reset_busy", int'(busy), 0);

    // plain SAR, threshold 677
    tick();
    run_sar(0, dn, pulses, lastp);
    chk("sar_done_cycle", dn, 61);
    chk("sar_pd_pulses", pulses, 10);
    chk("sar_last_pulse", lastp, 55);
    chk("sar_Q", int'(Q), 10'h2A5);
    chk("sar_T", int'(T), 16'h03FF);
    chk("sar_Tb", int'(Tb), 16'hFC00);
    chk("sar_locked", int'(locked), 0);
    @(negedge clk);
    chk("sar_busy_drop", int'(busy), 0);

    // stuck decisions
    tick(); pd_mode = 2'd1;
    run_sar(0, dn, pulses, lastp);
    chk("stuck1_Q", int'(Q), 10'h3FF);
    chk("stuck1_T", int'(T), 16'h7FFF);
    tick(); tick(); pd_mode = 2'd2;
    run_sar(0, dn, pulses, lastp);
    chk("stuck0_Q", int'(Q), 0);
    chk("stuck0_T", int'(T), 0);
    chk("stuck0_Tb", int'(Tb), 16'hFFFF);

    // start pulsed while busy must not restart
    tick(); tick(); pd_mode = 2'd0;
    run_sar(20, dn, pulses, lastp);
    chk("glitch_done_cycle", dn, 61);
    chk("glitch_Q", int'(Q), 10'h2A5);

    // reset mid-acquisition
    tick(); tick();
    start = 1'b1; tick(); start = 1'b0;
    repeat (29) tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_Q", int'(Q), 0);
    chk("midrst_T", int'(T), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_Reset_PD", int'(Reset_PD), 0);
    bad = 0;
    repeat (80) begin @(negedge clk); if (done || busy) bad++; end
    chk("midrst_no_done", bad, 0);

    // tracking and lock at 677/678
    tick(); track_en = 1'b1;
    run_sar(0, dn, pulses, lastp);
    chk("trk_done_cycle", dn, 61);
    k = 0;
    while (!locked && k < 300) begin @(negedge clk); k++; end
    chk("trk_lock_delay", k, 54);
    bad = 0;
    repeat (100 * P) begin
      @(negedge clk);
      if (!locked || !(Q == 10'd677 || Q == 10'd678)) bad++;
    end
    chk("trk_lock_hold", bad, 0);

    // threshold move: unlock, ramp, relock
    tick(); thr = 690;
    k = 0;
    while (locked && k < 100) begin @(negedge clk); k++; end
    chk("move_unlock_Q", int'(Q), 679);
    k = 0;
    while (!locked && k < 3000) begin @(negedge clk); k++; end
    chk("move_relock_Q", int'(Q == 10'd690 || Q == 10'd691), 1);
    chk("move_relock_seen", int'(locked), 1);

    // drop track_en while locked
    tick(); qh = int'(Q); track_en = 1'b0;
    k = 0;
    while (busy && k < 50) begin @(negedge clk); k++; end
    chk("drop_idle", int'(busy), 0);
    chk("drop_Q_hold", int'(Q), qh);
    chk("drop_unlocked", int'(locked), 0);
    bad = 0;
    repeat (30) begin @(negedge clk); if (Reset_PD) bad++; end
    chk("drop_no_pd", bad, 0);

    // saturation at full scale while tracking
    tick(); thr = 1023; track_en = 1'b1;
    run_sar(0, dn, pulses, lastp);
    chk("sat_sar_Q", int'(Q), 10'h3FF);
    repeat (20 * P) @(negedge clk);
    chk("sat_trk_Q", int'(Q), 10'h3FF);
    chk("sat_T", int'(T), 16'h7FFF);
    tick(); track_en = 1'b0;
    repeat (2 * P) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
